// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants and helpers for the VGA raster generator.
//   - 640x480@60 default line/frame geometry (visible, porch, sync)
//   - calcTotal: derives H_TOTAL / V_TOTAL from the four region widths
//   - inSyncRegion: tells whether a counter value lies inside the sync pulse
//   - pipe_bundle_t: the per-pixel bundle carried through the output delay line
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    // One pixel's worth of decoded timing plus the game colour for that pixel.
    typedef struct packed {
        logic       visible;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } pipe_bundle_t;

    localparam int BUNDLE_W = $bits(pipe_bundle_t);

    function automatic int calcTotal(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    // The sync pulse sits directly after the front porch.
    function automatic logic inSyncRegion(input int pos, input int visible, input int fp, input int sync);
        return (pos >= visible + fp) && (pos < visible + fp + sync);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
// Plain register chain of configurable width and depth with an asynchronous
// active-low clear. The output is the last stage, so data emerges exactly
// DEPTH clocks after it is presented.
//   i_clk    : clock
//   i_resetN : asynchronous clear, active low
//   i_data   : WIDTH-bit input word
//   o_data   : WIDTH-bit word delayed by DEPTH clocks
module vga_delay_line #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_resetN,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift every stage one step per clock; clear all stages together on reset
    // so nothing stale can leak out after reset is released.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// Raster timing generator for a VGA monitor driven from the pixel clock.
// xpos/ypos are free-running raw counters (including blanking) that feed the
// game block; its combinational colour comes back and travels with the decoded
// sync/blank flags through PIPE_DELAY register stages (legal 1..4) so colour and
// sync reach the connector aligned.
//   clk25       : pixel clock
//   reset       : asynchronous reset, active low
//   red_in/green_in/blue_in : game colour for the current xpos/ypos
//   xpos, ypos  : undelayed pixel counters
//   hsync/vsync : delayed sync, polarity set by SYNC_ACTIVE
//   red/green/blue : delayed colour, forced to 0 outside the visible area
//   frame_start : one-cycle pulse when pixel (0,0) is at the output
//   frame_count : frames since reset, wraps at 16 bits
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int PIPE_DELAY  = 1
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic [2:0]  red_in,
    input  logic [2:0]  green_in,
    input  logic [1:0]  blue_in,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = calcTotal(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calcTotal(V_VISIBLE, V_FP, V_SYNC, V_BP);

    logic [9:0]   r_xpos;
    logic [9:0]   r_ypos;
    logic [15:0]  r_frameCount;
    pipe_bundle_t w_stage0;
    pipe_bundle_t w_delayed;

    // Raster counters. The line and frame wrap happen on the same edge, so
    // (H_TOTAL-1, V_TOTAL-1) goes straight to (0,0).
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            r_xpos <= '0;
            r_ypos <= '0;
        end else if (r_xpos == 10'(H_TOTAL - 1)) begin
            r_xpos <= '0;
            if (r_ypos == 10'(V_TOTAL - 1)) begin
                r_ypos <= '0;
            end else begin
                r_ypos <= r_ypos + 10'd1;
            end
        end else begin
            r_xpos <= r_xpos + 10'd1;
        end
    end

    // Stage-0 decode: timing flags for the pixel currently on the counters,
    // bundled with the colour the game is returning for that same pixel.
    always_comb begin
        w_stage0         = '0;
        w_stage0.visible = (int'(r_xpos) < H_VISIBLE) && (int'(r_ypos) < V_VISIBLE);
        w_stage0.hs      = inSyncRegion(int'(r_xpos), H_VISIBLE, H_FP, H_SYNC);
        w_stage0.vs      = inSyncRegion(int'(r_ypos), V_VISIBLE, V_FP, V_SYNC);
        w_stage0.fs      = (r_xpos == '0) && (r_ypos == '0);
        w_stage0.red     = red_in;
        w_stage0.green   = green_in;
        w_stage0.blue    = blue_in;
    end

    vga_delay_line #(
        .WIDTH (BUNDLE_W),
        .DEPTH (PIPE_DELAY)
    ) u_delayLine (
        .i_clk    (clk25),
        .i_resetN (reset),
        .i_data   (w_stage0),
        .o_data   (w_delayed)
    );

    // Counts the frame once the frame_start cycle has been presented, so the
    // value seen alongside frame_start is the count of earlier frames.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            r_frameCount <= '0;
        end else if (w_delayed.fs) begin
            r_frameCount <= r_frameCount + 16'd1;
        end
    end

    // Output stage is combinational on the last pipeline register: a cleared
    // pipeline therefore yields blank colour and inactive sync immediately on reset.
    assign red         = w_delayed.visible ? w_delayed.red   : 3'd0;
    assign green       = w_delayed.visible ? w_delayed.green : 3'd0;
    assign blue        = w_delayed.visible ? w_delayed.blue  : 2'd0;
    assign hsync       = w_delayed.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync       = w_delayed.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign frame_start = w_delayed.fs;
    assign frame_count = r_frameCount;
    assign xpos        = r_xpos;
    assign ypos        = r_ypos;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl.
// Two small-geometry instances (PIPE_DELAY 1 and 3) are checked every cycle by a
// scoreboard; a default-geometry instance is checked on its first line.
// Small geometry: line 16+4+6+6 = 32 clocks (hsync at x 20..25),
// frame 6+2+2+2 = 12 lines (vsync at y 8..9), frame period 384 clocks.
module tb_vga_timing_ctrl;

    localparam int HT = 32;
    localparam int VT = 12;
    localparam int VV = 6;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       fs;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } exp_t;

    logic clk25 = 1'b0;
    logic reset = 1'b0;

    always #20 clk25 = ~clk25;

    logic [2:0]  r1In, g1In;
    logic [1:0]  b1In;
    logic [9:0]  x1, y1, x3, y3, xD, yD;
    logic        hs1, vs1, fs1, hs3, vs3, fs3, hsD, vsD, fsD;
    logic [2:0]  red1, green1, red3, green3, redD, greenD;
    logic [1:0]  blue1, blue3, blueD;
    logic [15:0] fc1, fc3, fcD;
    logic [2:0]  r3In, g3In;
    logic [1:0]  b3In;

    // Game emulation for the deep-pipeline instance: colour is a function of xpos.
    assign r3In = x3[2:0];
    assign g3In = 3'd5;
    assign b3In = x3[4:3];

    vga_timing_ctrl #(
        .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VISIBLE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(1)
    ) dut1 (
        .clk25(clk25), .reset(reset),
        .red_in(r1In), .green_in(g1In), .blue_in(b1In),
        .xpos(x1), .ypos(y1), .hsync(hs1), .vsync(vs1),
        .red(red1), .green(green1), .blue(blue1),
        .frame_start(fs1), .frame_count(fc1)
    );

    vga_timing_ctrl #(
        .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VISIBLE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(3)
    ) dut3 (
        .clk25(clk25), .reset(reset),
        .red_in(r3In), .green_in(g3In), .blue_in(b3In),
        .xpos(x3), .ypos(y3), .hsync(hs3), .vsync(vs3),
        .red(red3), .green(green3), .blue(blue3),
        .frame_start(fs3), .frame_count(fc3)
    );

    vga_timing_ctrl dutD (
        .clk25(clk25), .reset(reset),
        .red_in(3'd7), .green_in(3'd7), .blue_in(2'd3),
        .xpos(xD), .ypos(yD), .hsync(hsD), .vsync(vsD),
        .red(redD), .green(greenD), .blue(blueD),
        .frame_start(fsD), .frame_count(fcD)
    );

    exp_t        q1[$];
    exp_t        q3[$];
    int          checks = 0;
    int          errors = 0;
    int          mx = 0;
    int          my = 0;
    logic [15:0] expFc1 = '0;
    logic [15:0] expFc3 = '0;
    bit          monOn = 1'b0;
    logic [7:0]  vec [8];

    // Expected connector values for a pixel at (x,y) with game colour r/g/b.
    function automatic exp_t model(input int x, input int y, input logic [2:0] r,
                                   input logic [2:0] g, input logic [1:0] b);
        exp_t e;
        bit   vis;
        vis  = (x < 16) && (y < 6);
        e.hs = !((x >= 20) && (x <= 25));
        e.vs = !((y >= 8) && (y <= 9));
        e.fs = (x == 0) && (y == 0);
        e.r  = vis ? r : 3'd0;
        e.g  = vis ? g : 3'd0;
        e.b  = vis ? b : 2'd0;
        return e;
    endfunction

    function automatic exp_t resetExp();
        exp_t e;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResetState(input string tag, input logic [9:0] x, input logic [9:0] y,
                                   input logic [7:0] rgb, input logic h, input logic v,
                                   input logic f, input logic [15:0] fc);
        checkOutput({tag, "Pos"}, 32'({x, y}), 32'd0);
        checkOutput({tag, "Out"}, 32'({rgb, h, v, f, fc}), 32'({8'd0, 1'b1, 1'b1, 1'b0, 16'd0}));
    endtask

    // Drive this cycle's inputs, queue the outputs they must produce later,
    // then step the reference counters to the next pixel.
    task automatic applyStimulus(input int k);
        {r1In, g1In, b1In} = vec[k % 8];
        q1.push_back(model(mx, my, r1In, g1In, b1In));
        q3.push_back(model(mx, my, mx[2:0], 3'd5, mx[4:3]));
        mx++;
        if (mx == HT) begin
            mx = 0;
            my++;
            if (my == VT) my = 0;
        end
    endtask

    // Queue preload: a depth-D pipeline shows D-1 reset entries before the
    // first pixel appears on the sample after the first edge.
    task automatic restartScoreboard();
        q1.delete();
        q3.delete();
        for (int i = 0; i < 2; i++) q3.push_back(resetExp());
        mx = 0;
        my = 0;
        expFc1 = '0;
        expFc3 = '0;
    endtask

    // Monitor: one output per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk25);
            #1;
            if (monOn) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL q1Empty got 0 entries expected 1 at %0t", $time);
                end else begin
                    e = q1.pop_front();
                    checkOutput("out1", 32'({hs1, vs1, fs1, red1, green1, blue1}), 32'(e));
                    checkOutput("fc1", 32'(fc1), 32'(expFc1));
                    if (e.fs) expFc1++;
                end
                if (q3.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL q3Empty got 0 entries expected 1 at %0t", $time);
                end else begin
                    e = q3.pop_front();
                    checkOutput("out3", 32'({hs3, vs3, fs3, red3, green3, blue3}), 32'(e));
                    checkOutput("fc3", 32'(fc3), 32'(expFc3));
                    if (e.fs) expFc3++;
                end
                checkOutput("pos1", 32'({x1, y1}), 32'({10'(mx), 10'(my)}));
                checkOutput("pos3", 32'({x3, y3}), 32'({10'(mx), 10'(my)}));
            end
        end
    end

    initial begin
        int  fsCount, lastFs, vsLow, firstVs, corner, hsDLow, firstHsD, forceK, postHsLow;
        bit  forced, hit;
        vec = '{8'hFF, 8'h00, 8'hA5, 8'h5A, 8'hE3, 8'h1C, 8'h92, 8'h6D};
        fsCount = 0; lastFs = -1; vsLow = 0; firstVs = -1; corner = 0;
        hsDLow = 0; firstHsD = -1; forceK = -1; forced = 0; hit = 0; postHsLow = 0;

        r1In = 3'd7; g1In = 3'd7; b1In = 2'd3;
        $display("[TB] reset phase");
        repeat (5) begin
            @(negedge clk25);
            checkResetState("rst1", x1, y1, {red1, green1, blue1}, hs1, vs1, fs1, fc1);
            checkResetState("rst3", x3, y3, {red3, green3, blue3}, hs3, vs3, fs3, fc3);
        end

        @(negedge clk25);
        restartScoreboard();
        reset = 1'b1;
        monOn = 1'b1;
        $display("[TB] free run");
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) @(negedge clk25);
            if (k > 1600 && mx == 23 && my == 9) begin
                hit = 1;
                break;
            end
            if (k < 3 * FRAME) begin
                if (fs1) begin
                    fsCount++;
                    if (lastFs >= 0) checkOutput("framePeriod", 32'(k - lastFs), 32'(FRAME));
                    lastFs = k;
                end
                if (!vs1) begin
                    vsLow++;
                    if (firstVs < 0) firstVs = k;
                end
                if (x1 == 10'd0 && y1 == 10'(VV)) corner++;
            end
            if (k >= 1 && k <= 800 && !hsD) begin
                hsDLow++;
                if (firstHsD < 0) firstHsD = k;
            end
            if (k == 640) checkOutput("defRed639", 32'(redD), 32'd7);
            if (k == 641) checkOutput("defRed640", 32'(redD), 32'd0);
            if (k == 799) checkOutput("defX799", 32'({xD, yD}), 32'({10'd799, 10'd0}));
            if (k == 800) checkOutput("defWrap", 32'({xD, yD}), 32'({10'd0, 10'd1}));
            if (k == 1600) begin
                checkOutput("fcWrap", 32'(fc1), 32'd0);
                checkOutput("fc3Count", 32'(fc3), 32'd5);
            end
            if (k > 3 * FRAME && !forced && mx == 5 && my == 3) begin
                force dut1.r_frameCount = 16'hFFFF;
                expFc1 = 16'hFFFF;
                forced = 1;
                forceK = k;
            end else if (forced && k == forceK + 1) begin
                release dut1.r_frameCount;
            end
            applyStimulus(k);
        end

        checkOutput("fsCount", 32'(fsCount), 32'd3);
        checkOutput("vsLowCycles", 32'(vsLow), 32'(2 * HT * 3));
        checkOutput("firstVsLow", 32'(firstVs), 32'(8 * HT + 1));
        checkOutput("cornerPerFrame", 32'(corner), 32'd3);
        checkOutput("defHsLowCycles", 32'(hsDLow), 32'd96);
        checkOutput("defFirstHsLow", 32'(firstHsD), 32'd657);
        checkOutput("midResetReached", 32'(hit), 32'd1);

        $display("[TB] mid-frame reset");
        monOn = 1'b0;
        checkOutput("preSync1", 32'({hs1, vs1}), 32'd0);
        checkOutput("preSync3", 32'({hs3, vs3}), 32'd0);
        reset = 1'b0;
        #1;
        checkResetState("mid1", x1, y1, {red1, green1, blue1}, hs1, vs1, fs1, fc1);
        checkResetState("mid3", x3, y3, {red3, green3, blue3}, hs3, vs3, fs3, fc3);
        repeat (3) @(negedge clk25);
        restartScoreboard();
        reset = 1'b1;
        monOn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk25);
            if (k >= 1 && k <= HT && !hs1) postHsLow++;
            applyStimulus(k);
        end
        checkOutput("postResetHsLow", 32'(postHsLow), 32'd6);

        @(negedge clk25);
        monOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
